// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP frame sequencer: image geometry, bus widths
// and the sequencer state encoding.
package lbp_pkg;

    localparam int IMG_W   = 128;
    localparam int IMG_PIX = IMG_W * IMG_W;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;

    // Address of the last pixel of a frame; the load counter stops here.
    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(IMG_PIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/lbp_load_counter.sv
// Raster write address generator for the frame load phase.
// Clear has priority over enable; last flags the final pixel address.
module lbp_load_counter
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    // Next count: hold at zero while cleared, step on each accepted pixel.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared by the system reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LOAD_LAST);

endmodule

// File: rtl/lbp_frame_sequencer.sv
// Frame-level controller: loads one gray frame from the host stream into the
// single-port memory, lends the memory to the LBP engine, then re-arms the
// engine and reports the completed frame.
module lbp_frame_sequencer
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_finish,
    output logic              lbp_rst,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic              proto_err
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [7:0]        frame_cnt_q;
    logic [7:0]        frame_cnt_d;
    logic              proto_err_q;
    logic              proto_err_d;

    logic              accept;
    logic [ADDR_W-1:0] load_cnt;
    logic              load_last;

    assign accept = (state_q == ST_LOAD) && host_valid;

    // The counter is parked at zero in IDLE so every frame loads from address 0.
    lbp_load_counter u_load_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == ST_IDLE),
        .enable (accept),
        .count  (load_cnt),
        .last   (load_last)
    );

    // Next-state, frame counter and sticky protocol error computation.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        proto_err_d = proto_err_q | (gray_req && (state_q != ST_RUN));
        case (state_q)
            ST_IDLE: if (frame_start)            state_d = ST_LOAD;
            ST_LOAD: if (accept && load_last)    state_d = ST_RUN;
            ST_RUN:  if (lbp_finish)             state_d = ST_DONE;
            ST_DONE: begin
                state_d     = ST_IDLE;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            default:                             state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= 8'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Memory port mux: host writes during LOAD, LBP reads during RUN, parked at 0 otherwise.
    always_comb begin
        mem_addr = '0;
        case (state_q)
            ST_LOAD: mem_addr = load_cnt;
            ST_RUN:  mem_addr = gray_addr;
            default: mem_addr = '0;
        endcase
    end

    assign host_ready = (state_q == ST_LOAD);
    assign mem_we     = accept;
    assign mem_wdata  = accept ? host_data : '0;
    assign gray_ready = (state_q == ST_RUN);
    assign gray_data  = (state_q == ST_RUN) ? mem_rdata : '0;
    assign frame_done = (state_q == ST_DONE);
    assign lbp_rst    = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign frame_cnt  = frame_cnt_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_lbp_frame_sequencer.sv
// Randomized bench for lbp_frame_sequencer: the bench owns the gray memory,
// remembers every streamed pixel and checks writes, reads and frame control.
module tb_lbp_frame_sequencer;
    import lbp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              lbp_finish;
    logic              lbp_rst;
    logic              frame_done;
    logic              busy;
    logic [7:0]        frame_cnt;
    logic              proto_err;

    logic [DATA_W-1:0] gmem   [IMG_PIX];
    logic [DATA_W-1:0] expImg [IMG_PIX];
    int                checks  = 0;
    int                errors  = 0;
    int                expCnt  = 0;
    logic              expProto = 1'b0;

    lbp_frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .gray_ready  (gray_ready),
        .gray_req    (gray_req),
        .gray_addr   (gray_addr),
        .gray_data   (gray_data),
        .lbp_finish  (lbp_finish),
        .lbp_rst     (lbp_rst),
        .frame_done  (frame_done),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    // Single-port gray memory with asynchronous read.
    always @(posedge clk) begin
        if (mem_we) gmem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = gmem[mem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic fs, input logic hv, input logic [DATA_W-1:0] hd,
                                 input logic gr, input logic [ADDR_W-1:0] ga, input logic lf);
        frame_start = fs;
        host_valid  = hv;
        host_data   = hd;
        gray_req    = gr;
        gray_addr   = ga;
        lbp_finish  = lf;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_host_ready"}, 32'(host_ready), 32'd0);
        checkOutput({tag, "_busy"},       32'(busy),       32'd0);
        checkOutput({tag, "_mem_we"},     32'(mem_we),     32'd0);
        checkOutput({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        checkOutput({tag, "_gray_ready"}, 32'(gray_ready), 32'd0);
        checkOutput({tag, "_gray_data"},  32'(gray_data),  32'd0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_lbp_rst"},    32'(lbp_rst),    32'd0);
        checkOutput({tag, "_frame_cnt"},  32'(frame_cnt),  32'(expCnt));
        checkOutput({tag, "_proto_err"},  32'(proto_err),  32'(expProto));
    endtask

    // Stream a frame from IDLE; stops after stopAfter accepted pixels if non-zero.
    task automatic loadFrame(input int validPct, input bit pokeStart, input int stopAfter);
        int   idx;
        int   guard;
        int   limit;
        logic hv;
        logic [DATA_W-1:0] hd;
        limit = (stopAfter != 0) ? stopAfter : IMG_PIX;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("req_host_ready", 32'(host_ready), 32'd0);
        checkOutput("req_busy", 32'(busy), 32'd0);
        nextCycle;
        idx   = 0;
        guard = 0;
        while (idx < limit && guard < 4 * IMG_PIX) begin
            hv = ($urandom_range(99) < validPct);
            hd = DATA_W'($urandom);
            applyStimulus(pokeStart && ($urandom_range(63) == 0), hv, hd, 1'b0, '0, 1'b0);
            @(negedge clk);
            checkOutput("load_host_ready", 32'(host_ready), 32'd1);
            checkOutput("load_busy", 32'(busy), 32'd1);
            checkOutput("load_gray_ready", 32'(gray_ready), 32'd0);
            checkOutput("load_mem_we", 32'(mem_we), 32'(hv));
            if (hv) begin
                checkOutput("load_mem_addr", 32'(mem_addr), 32'(idx));
                checkOutput("load_mem_wdata", 32'(mem_wdata), 32'(hd));
                expImg[idx] = hd;
                idx++;
            end
            nextCycle;
            guard++;
        end
        checkOutput("load_count", 32'(idx), 32'(limit));
    endtask

    // Exercise the LBP read port, then finish and return to IDLE.
    task automatic runAndFinish(input int runReads, input bit pokeStart);
        logic [ADDR_W-1:0] addr;
        logic hv;
        for (int r = 0; r < runReads; r++) begin
            addr = ADDR_W'($urandom_range(IMG_PIX - 1));
            hv   = 1'($urandom_range(1));
            applyStimulus(pokeStart && ($urandom_range(15) == 0), hv, 8'hA5, 1'b1, addr, 1'b0);
            @(negedge clk);
            checkOutput("run_gray_ready", 32'(gray_ready), 32'd1);
            checkOutput("run_host_ready", 32'(host_ready), 32'd0);
            checkOutput("run_mem_we", 32'(mem_we), 32'd0);
            checkOutput("run_mem_addr", 32'(mem_addr), 32'(addr));
            checkOutput("run_gray_data", 32'(gray_data), 32'(expImg[addr]));
            checkOutput("run_proto_err", 32'(proto_err), 32'(expProto));
            nextCycle;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("fin_frame_done", 32'(frame_done), 32'd0);
        checkOutput("fin_gray_ready", 32'(gray_ready), 32'd1);
        nextCycle;
        applyStimulus(pokeStart, 1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("done_frame_done", 32'(frame_done), 32'd1);
        checkOutput("done_lbp_rst", 32'(lbp_rst), 32'd1);
        checkOutput("done_gray_ready", 32'(gray_ready), 32'd0);
        checkOutput("done_gray_data", 32'(gray_data), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd1);
        checkOutput("done_frame_cnt", 32'(frame_cnt), 32'(expCnt));
        expCnt = (expCnt + 1) % 256;
        nextCycle;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkQuiet("after_done");
        nextCycle;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkQuiet("rst");
        nextCycle;
        reset = 1'b0;
        @(negedge clk);
        checkQuiet("idle");
        nextCycle;

        $display("[TB] frame 1: gappy host stream");
        loadFrame(70, 1'b0, 0);
        runAndFinish(300, 1'b0);

        $display("[TB] gray_req outside RUN");
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 14'd123, 1'b1);
        @(negedge clk);
        checkOutput("proto_before", 32'(proto_err), 32'd0);
        nextCycle;
        expProto = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkQuiet("proto_after");
        nextCycle;

        $display("[TB] frame 2: full-rate stream with stray frame_start");
        loadFrame(100, 1'b1, 0);
        runAndFinish(300, 1'b1);

        $display("[TB] reset in the middle of LOAD");
        loadFrame(100, 1'b0, 5000);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, '0, 1'b0);
        #1;
        expCnt   = 0;
        expProto = 1'b0;
        checkQuiet("midrst");
        nextCycle;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkQuiet("post_rst");
        nextCycle;

        $display("[TB] frame 3: reload from address 0");
        loadFrame(100, 1'b0, 0);
        runAndFinish(200, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
